// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Holds the PC, fetches from a combinational instruction memory and
// selects the next PC: taken branch (EX), jump (ID) or sequential.
// Counts flush events in a saturating counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc_plus4,
  output logic             if_id_valid,
  output logic [5:0]       opcode,
  output logic             flush_id,
  output logic [CNT_W-1:0] flush_count
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic        jump_eff;
  logic        flush_evt;

  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00};
  // Control may drive garbage on bubbles, so only a real instruction can jump.
  assign jump_eff    = jump & if_id_valid;
  // A stalled jump is not a flush yet; it fires when the stall releases.
  assign flush_evt   = branch_taken | (enable & jump_eff);

  assign imem_addr = pc;
  assign opcode    = if_id_instr[31:26];
  assign flush_id  = branch_taken;

  // PC and IF/ID update: branch beats stall beats jump beats sequential.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= RESET_PC + 32'd4;
      if_id_valid    <= 1'b0;
    end else if (branch_taken) begin
      // if_id_pc_plus4 intentionally holds; the bubble carries no PC.
      pc          <= branch_target;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (enable) begin
      if (jump_eff) begin
        pc          <= jump_target;
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end else begin
        pc             <= pc_plus4;
        if_id_instr    <= imem_data;
        if_id_pc_plus4 <= pc_plus4;
        if_id_valid    <= 1'b1;
      end
    end
  end

  // Saturating flush counter; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      flush_count <= '0;
    else if (flush_evt && !(&flush_count))
      flush_count <= flush_count + 1'b1;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, jump,
// branch during stall, PC wrap, counter saturation, reset mid-flush.
module tb_fetch_stage;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc_plus4;
  logic             if_id_valid;
  logic [5:0]       opcode;
  logic             flush_id;
  logic [CNT_W-1:0] flush_count;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid   (if_id_valid),
    .opcode        (opcode),
    .flush_id      (flush_id),
    .flush_count   (flush_count)
  );

  // Combinational instruction memory model.
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_data = 32'h2008_0005;
      32'h0000_0004: imem_data = 32'h2009_0007;
      32'h0000_0008: imem_data = 32'h0800_0010; // j 0x40
      32'h0000_0040: imem_data = 32'h2010_0001;
      default:       imem_data = 32'h0000_0020;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; branch_taken = 1'b0;
    branch_target = 32'h0; jump = 1'b0;
    #2;
    // Reset state
    step();
    chk("rst_pc",    imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4",   if_id_pc_plus4, 32'h4);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_cnt",   32'(flush_count), 32'h0);
    chk("rst_flush", 32'(flush_id), 32'h0);

    // Sequential fetch
    rst = 1'b0;
    step();
    chk("seq1_pc",    imem_addr, 32'h4);
    chk("seq1_instr", if_id_instr, 32'h2008_0005);
    chk("seq1_pc4",   if_id_pc_plus4, 32'h4);
    chk("seq1_valid", 32'(if_id_valid), 32'h1);
    chk("seq1_op",    32'(opcode), 32'h08);
    step();
    chk("seq2_pc",    imem_addr, 32'h8);
    chk("seq2_instr", if_id_instr, 32'h2009_0007);
    chk("seq2_pc4",   if_id_pc_plus4, 32'h8);

    // Stall three cycles at PC=8
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",    imem_addr, 32'h8);
      chk("stall_instr", if_id_instr, 32'h2009_0007);
      chk("stall_pc4",   if_id_pc_plus4, 32'h8);
    end
    enable = 1'b1;
    step();
    chk("rel_pc",    imem_addr, 32'hC);
    chk("rel_instr", if_id_instr, 32'h0800_0010);
    chk("rel_valid", 32'(if_id_valid), 32'h1);

    // Jump to 0x40
    jump = 1'b1;
    step();
    chk("j_pc",    imem_addr, 32'h40);
    chk("j_valid", 32'(if_id_valid), 32'h0);
    chk("j_instr", if_id_instr, 32'h0);
    chk("j_cnt",   32'(flush_count), 32'h1);
    jump = 1'b0;
    step();
    chk("j2_pc",    imem_addr, 32'h44);
    chk("j2_instr", if_id_instr, 32'h2010_0001);
    chk("j2_valid", 32'(if_id_valid), 32'h1);

    // Taken branch while stalled with a pending jump
    branch_taken = 1'b1; branch_target = 32'h100; enable = 1'b0; jump = 1'b1;
    #1;
    chk("br_flush_id", 32'(flush_id), 32'h1);
    step();
    chk("br_pc",    imem_addr, 32'h100);
    chk("br_valid", 32'(if_id_valid), 32'h0);
    chk("br_pc4",   if_id_pc_plus4, 32'h44);
    chk("br_cnt",   32'(flush_count), 32'h2);

    // Wrap at top of address space
    jump = 1'b0; enable = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    chk("wr_pc",  imem_addr, 32'hFFFF_FFFC);
    chk("wr_cnt", 32'(flush_count), 32'h3);
    branch_taken = 1'b0;
    step();
    chk("wrap_pc",    imem_addr, 32'h0);
    chk("wrap_pc4",   if_id_pc_plus4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h0000_0020);
    chk("wrap_valid", 32'(if_id_valid), 32'h1);

    // Counter saturation (flushes 4 and 5)
    branch_taken = 1'b1; branch_target = 32'h200;
    step();
    chk("sat4_cnt", 32'(flush_count), 32'h3);
    branch_target = 32'h300;
    step();
    chk("sat5_cnt", 32'(flush_count), 32'h3);
    chk("sat5_pc",  imem_addr, 32'h300);

    // Reset coincident with a taken branch
    rst = 1'b1; branch_target = 32'h500;
    step();
    chk("rb_pc",    imem_addr, 32'h0);
    chk("rb_cnt",   32'(flush_count), 32'h0);
    chk("rb_valid", 32'(if_id_valid), 32'h0);
    chk("rb_pc4",   if_id_pc_plus4, 32'h4);

    // Jump on a bubble is ignored
    rst = 1'b0; branch_taken = 1'b0; jump = 1'b1;
    step();
    chk("jb_pc",    imem_addr, 32'h4);
    chk("jb_valid", 32'(if_id_valid), 32'h1);
    chk("jb_cnt",   32'(flush_count), 32'h0);
    jump = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
